// File: rtl/npc_seq_if.sv
// ============================================================================
// Module   : npc_seq_if
// Brief    : Fetch request bus between the next-PC sequencer and the I-cache.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface npc_seq_if #(
    parameter int FETCH_WIDTH = 2
) ();
    localparam int c_slot_w = $clog2(FETCH_WIDTH) + 1;

    logic                fetch_ready;
    logic                fetch_valid;
    logic [31:0]         fetch_pc;
    logic [c_slot_w-1:0] fetch_slots;

    modport master (
        input  fetch_ready,
        output fetch_valid,
        output fetch_pc,
        output fetch_slots
    );

    modport slave (
        output fetch_ready,
        input  fetch_valid,
        input  fetch_pc,
        input  fetch_slots
    );
endinterface

`default_nettype wire

// File: rtl/npc_seq.sv
// ============================================================================
// Module   : npc_seq
// Brief    : Registered next-PC sequencer with stall-safe redirect buffering.
// Revision : 1.0
// ============================================================================
`default_nettype none

module npc_seq #(
    parameter int          FETCH_WIDTH = 2,
    parameter logic [31:0] RESET_PC    = 32'hBFC0_0000
) (
    input  wire logic        clk,
    input  wire logic        resetn,
    npc_seq_if.master        fetch,
    input  wire logic        id2_is_branch,
    input  wire logic        id2_is_jump,
    input  wire logic [3:0]  id2_branch_sel,
    input  wire logic [31:0] id2_rs_data,
    input  wire logic [31:0] id2_rt_data,
    input  wire logic [31:0] id2_jmp_target,
    input  wire logic        exc_valid,
    input  wire logic [31:0] exc_pc,
    output logic             flush_req,
    output logic             redirect_pending
);

    localparam int c_gb     = 4 * FETCH_WIDTH;
    localparam int c_gb_lg  = $clog2(c_gb);
    localparam int c_slot_w = $clog2(FETCH_WIDTH) + 1;
    localparam logic [31-c_gb_lg:0] c_grp_one = 1;

    // Branch condition encodings, matching branch_def.v
    localparam logic [3:0] c_branch_sel_beq    = 4'd0;
    localparam logic [3:0] c_branch_sel_bne    = 4'd1;
    localparam logic [3:0] c_branch_sel_bgez   = 4'd2;
    localparam logic [3:0] c_branch_sel_bgtz   = 4'd3;
    localparam logic [3:0] c_branch_sel_blez   = 4'd4;
    localparam logic [3:0] c_branch_sel_bltz   = 4'd5;
    localparam logic [3:0] c_branch_sel_bgezal = 4'd6;
    localparam logic [3:0] c_branch_sel_bltzal = 4'd7;

    typedef enum logic [2:0] {
        ST_RUN      = 3'b001,
        ST_PEND_BR  = 3'b010,
        ST_PEND_EXC = 3'b100
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_pend_tgt, w_pend_tgt_nxt;
    logic        r_valid;

    logic        w_fire;
    logic        w_cond;
    logic        w_take_br;
    logic [31:0] w_seq;
    logic [31-c_gb_lg:0] w_grp_nxt;

    assign w_fire    = r_valid & fetch.fetch_ready;
    assign w_grp_nxt = r_pc[31:c_gb_lg] + c_grp_one;
    assign w_seq     = {w_grp_nxt, {c_gb_lg{1'b0}}};

    always_comb begin
        w_cond = 1'b0;
        case (id2_branch_sel)
            c_branch_sel_beq:    w_cond = (id2_rs_data == id2_rt_data);
            c_branch_sel_bne:    w_cond = (id2_rs_data != id2_rt_data);
            c_branch_sel_bgez,
            c_branch_sel_bgezal: w_cond = ~id2_rs_data[31];
            c_branch_sel_bgtz:   w_cond = ~id2_rs_data[31] & (|id2_rs_data[30:0]);
            c_branch_sel_blez:   w_cond = id2_rs_data[31] | ~(|id2_rs_data);
            c_branch_sel_bltz,
            c_branch_sel_bltzal: w_cond = id2_rs_data[31];
            default:             w_cond = 1'b0;
        endcase
    end

    assign w_take_br        = id2_is_jump | (id2_is_branch & w_cond);
    assign flush_req        = exc_valid | w_take_br;
    assign redirect_pending = (r_state != ST_RUN);

    // The PC only moves on fire, so a stalled request is held stable.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_pend_tgt_nxt = r_pend_tgt;
        case (r_state)
            ST_RUN: begin
                if (exc_valid) begin
                    if (w_fire) begin
                        w_pc_nxt = exc_pc;
                    end else begin
                        w_pend_tgt_nxt = exc_pc;
                        w_state_nxt    = ST_PEND_EXC;
                    end
                end else if (w_take_br) begin
                    if (w_fire) begin
                        w_pc_nxt = id2_jmp_target;
                    end else begin
                        w_pend_tgt_nxt = id2_jmp_target;
                        w_state_nxt    = ST_PEND_BR;
                    end
                end else if (w_fire) begin
                    w_pc_nxt = w_seq;
                end
            end
            ST_PEND_BR: begin
                if (exc_valid) begin
                    w_pend_tgt_nxt = exc_pc;
                    if (w_fire) begin
                        w_pc_nxt    = exc_pc;
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_state_nxt = ST_PEND_EXC;
                    end
                end else if (w_fire) begin
                    w_pc_nxt    = r_pend_tgt;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_PEND_EXC: begin
                if (exc_valid) begin
                    w_pend_tgt_nxt = exc_pc;
                end
                if (w_fire) begin
                    w_pc_nxt    = exc_valid ? exc_pc : r_pend_tgt;
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_RUN;
            r_pc       <= RESET_PC;
            r_pend_tgt <= 32'h0;
            r_valid    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_pend_tgt <= w_pend_tgt_nxt;
            r_valid    <= 1'b1;
        end
    end

    assign fetch.fetch_valid = r_valid;
    assign fetch.fetch_pc    = r_pc;

    generate
        if (FETCH_WIDTH == 1) begin : g_slots_single
            assign fetch.fetch_slots = 1'b1;
        end else begin : g_slots_group
            assign fetch.fetch_slots = c_slot_w'(FETCH_WIDTH) - {1'b0, r_pc[c_gb_lg-1:2]};
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_npc_seq.sv
// ============================================================================
// Module   : tb_npc_seq
// Brief    : Randomized and directed bench for npc_seq against a redirect model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_npc_seq;

    localparam int          FW  = 2;
    localparam int          GB  = 4 * FW;
    localparam logic [31:0] RPC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        id2_is_branch, id2_is_jump, exc_valid;
    logic [3:0]  id2_branch_sel;
    logic [31:0] id2_rs_data, id2_rt_data, id2_jmp_target, exc_pc;
    logic        flush_req, redirect_pending;

    npc_seq_if #(.FETCH_WIDTH(FW)) fif ();

    npc_seq #(.FETCH_WIDTH(FW), .RESET_PC(RPC)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .fetch            (fif),
        .id2_is_branch    (id2_is_branch),
        .id2_is_jump      (id2_is_jump),
        .id2_branch_sel   (id2_branch_sel),
        .id2_rs_data      (id2_rs_data),
        .id2_rt_data      (id2_rt_data),
        .id2_jmp_target   (id2_jmp_target),
        .exc_valid        (exc_valid),
        .exc_pc           (exc_pc),
        .flush_req        (flush_req),
        .redirect_pending (redirect_pending)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: visible PC, valid, and an optional buffered redirect
    logic [31:0] m_pc;
    logic        m_valid;
    logic        m_pend;
    logic [31:0] m_ptgt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic ref_cond(input logic [3:0] sel, input logic [31:0] rs,
                                      input logic [31:0] rt);
        case (sel)
            4'd0:       return rs == rt;
            4'd1:       return rs != rt;
            4'd2, 4'd6: return $signed(rs) >= 0;
            4'd3:       return $signed(rs) > 0;
            4'd4:       return $signed(rs) <= 0;
            4'd5, 4'd7: return $signed(rs) < 0;
            default:    return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_pc    = RPC;
        m_valid = 1'b0;
        m_pend  = 1'b0;
        m_ptgt  = 32'h0;
    endtask

    task automatic step(input logic rdy, input logic br, input logic jmp, input logic [3:0] sel,
                        input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] tgt,
                        input logic exc, input logic [31:0] epc, output logic flush_obs);
        logic        take, fire, redir;
        logic [31:0] rtgt, seq;
        fif.fetch_ready = rdy;
        id2_is_branch   = br;
        id2_is_jump     = jmp;
        id2_branch_sel  = sel;
        id2_rs_data     = rs;
        id2_rt_data     = rt;
        id2_jmp_target  = tgt;
        exc_valid       = exc;
        exc_pc          = epc;
        #1;
        take = jmp | (br & ref_cond(sel, rs, rt));
        fire = m_valid & rdy;
        chk("flush_req", 32'(flush_req), 32'(exc | take));
        chk("fetch_pc", fif.fetch_pc, m_pc);
        chk("fetch_valid", 32'(fif.fetch_valid), 32'(m_valid));
        chk("fetch_slots", 32'(fif.fetch_slots), 32'(FW - ((m_pc >> 2) % FW)));
        chk("redirect_pending", 32'(redirect_pending), 32'(m_pend));
        flush_obs = flush_req;
        // An exception always wins; otherwise an older buffered redirect beats a new branch
        redir = exc | m_pend | take;
        rtgt  = exc ? epc : (m_pend ? m_ptgt : tgt);
        seq   = (m_pc / 32'(GB)) * 32'(GB) + 32'(GB);
        @(posedge clk);
        #1;
        if (fire) begin
            m_pc   = redir ? rtgt : seq;
            m_pend = 1'b0;
        end else if (redir) begin
            m_pend = 1'b1;
            m_ptgt = rtgt;
        end
        m_valid = 1'b1;
    endtask

    task automatic idle(input logic rdy);
        logic f;
        step(rdy, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, f);
    endtask

    initial begin
        logic f;
        resetn = 1'b0;
        fif.fetch_ready = 1'b0;
        id2_is_branch = 1'b0; id2_is_jump = 1'b0; id2_branch_sel = 4'd0;
        id2_rs_data = 32'h0; id2_rt_data = 32'h0; id2_jmp_target = 32'h0;
        exc_valid = 1'b0; exc_pc = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", fif.fetch_pc, RPC);
        chk("rst_valid", 32'(fif.fetch_valid), 32'h0);
        chk("rst_pending", 32'(redirect_pending), 32'h0);
        resetn = 1'b1;

        // Sequential groups after reset
        idle(1'b1);
        chk("seq0_pc", fif.fetch_pc, 32'hBFC0_0000);
        idle(1'b1);
        chk("seq1_pc", fif.fetch_pc, 32'hBFC0_0008);
        idle(1'b1);
        chk("seq2_pc", fif.fetch_pc, 32'hBFC0_0010);
        chk("seq2_slots", 32'(fif.fetch_slots), 32'd2);

        // Same-cycle taken BEQ
        step(1'b1, 1'b1, 1'b0, 4'd0, 32'd5, 32'd5, 32'hBFC0_0104, 1'b0, 32'h0, f);
        chk("beq_flush", 32'(f), 32'd1);
        chk("beq_pc", fif.fetch_pc, 32'hBFC0_0104);
        chk("beq_slots", 32'(fif.fetch_slots), 32'd1);
        idle(1'b1);
        chk("beq_next_pc", fif.fetch_pc, 32'hBFC0_0108);

        // Stalled BNE held until the request is accepted
        step(1'b0, 1'b1, 1'b0, 4'd1, 32'd1, 32'd2, 32'h8000_0010, 1'b0, 32'h0, f);
        idle(1'b0);
        idle(1'b0);
        chk("bne_held_pc", fif.fetch_pc, 32'hBFC0_0108);
        chk("bne_pending", 32'(redirect_pending), 32'd1);
        idle(1'b1);
        chk("bne_pc", fif.fetch_pc, 32'h8000_0010);
        chk("bne_pending_clr", 32'(redirect_pending), 32'd0);

        // Exception overrides a buffered branch
        step(1'b0, 1'b1, 1'b0, 4'd0, 32'd3, 32'd3, 32'h8000_0010, 1'b0, 32'h0, f);
        step(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 1'b1, 32'hBFC0_0380, f);
        idle(1'b1);
        chk("exc_over_br_pc", fif.fetch_pc, 32'hBFC0_0380);

        // Condition corner cases
        step(1'b1, 1'b1, 1'b0, 4'd3, 32'h8000_0000, 32'h0, 32'h1111_1110, 1'b0, 32'h0, f);
        chk("bgtz_neg_flush", 32'(f), 32'd0);
        step(1'b1, 1'b1, 1'b0, 4'd4, 32'h0, 32'h0, 32'h8000_0100, 1'b0, 32'h0, f);
        chk("blez_zero_flush", 32'(f), 32'd1);
        chk("blez_zero_pc", fif.fetch_pc, 32'h8000_0100);
        step(1'b1, 1'b1, 1'b0, 4'hF, 32'd7, 32'd7, 32'h2222_2220, 1'b0, 32'h0, f);
        chk("unknown_sel_flush", 32'(f), 32'd0);

        // Address wrap
        step(1'b1, 1'b0, 1'b1, 4'd0, 32'h0, 32'h0, 32'hFFFF_FFF8, 1'b0, 32'h0, f);
        idle(1'b1);
        chk("wrap_pc", fif.fetch_pc, 32'h0000_0000);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] rt;
            logic [31:0] rs;
            rt = ($urandom % 4 == 0) ? 32'h0 : $urandom;
            rs = ($urandom % 3 == 0) ? rt : $urandom;
            step(($urandom % 4) != 0, ($urandom % 4) == 0, ($urandom % 8) == 0,
                 4'($urandom_range(0, 15)), rs, rt, $urandom & 32'hFFFF_FFFC,
                 ($urandom % 10) == 0, $urandom & 32'hFFFF_FFFC, f);
        end

        // Asynchronous reset while a branch is buffered
        step(1'b0, 1'b1, 1'b0, 4'd1, 32'd1, 32'd2, 32'h1234_0000, 1'b0, 32'h0, f);
        chk("pre_rst_pending", 32'(redirect_pending), 32'd1);
        #2 resetn = 1'b0;
        #1;
        chk("async_rst_pc", fif.fetch_pc, RPC);
        chk("async_rst_valid", 32'(fif.fetch_valid), 32'h0);
        chk("async_rst_pending", 32'(redirect_pending), 32'h0);
        model_reset();
        @(posedge clk);
        #1 resetn = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step(($urandom % 3) != 0, ($urandom % 4) == 0, ($urandom % 8) == 0,
                 4'($urandom_range(0, 15)), $urandom, $urandom, $urandom & 32'hFFFF_FFFC,
                 ($urandom % 12) == 0, $urandom & 32'hFFFF_FFFC, f);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/npc_seq.md
# npc_seq

Registered next-PC sequencer for the instruction fetch unit. It holds the fetch PC and drives fetch-group addresses to the I-cache over a valid/ready handshake. Branches resolved in ID2 and exceptions redirect fetch; a redirect that arrives while a request is stalled is latched until the held request is accepted. It generalises the single-cycle next-PC logic to a configurable fetch-group width and adds stall-safe redirect buffering.

## Interface
- `FETCH_WIDTH`, default 2: instructions per fetch group; legal values are 1, 2 and 4. Group size in bytes is `GB = 4*FETCH_WIDTH`.
- `RESET_PC`, default 32'hBFC0_0000: first fetch address after reset.
- Clock and reset (already decided): one clock, `clk`; reset `resetn` is asynchronous and active-low.
- `clk`  in  1  clock
- `resetn`  in  1  asynchronous active-low reset
- `fetch_ready`  in  1  I-cache accepts `fetch_pc` this cycle
- `fetch_valid`  out  1  request valid
- `fetch_pc`  out  32  current fetch address
- `fetch_slots`  out  clog2(FETCH_WIDTH)+1  number of valid instructions from `fetch_pc` to the end of its group
- `id2_is_branch`  in  1  conditional branch in ID2
- `id2_is_jump`  in  1  J, JAL, JR or JALR in ID2 (always taken)
- `id2_branch_sel`  in  4  branch condition, using the `BRANCH_SEL_*` encodings in branch_def.v
- `id2_rs_data`, `id2_rt_data`  in  32 each  branch operands
- `id2_jmp_target`  in  32  redirect target
- `exc_valid`  in  1  exception redirect request
- `exc_pc`  in  32  exception vector
- `flush_req`  out  1  kill all younger fetched instructions; combinational, high in the resolve cycle
- `redirect_pending`  out  1  a latched redirect is waiting for a handshake

## Operation
- `fire = fetch_valid & fetch_ready`.
- Sequential address: `seq = (fetch_pc & ~(GB-1)) + GB`, modulo 2^32 (wraps to 0).
- `fetch_slots = FETCH_WIDTH - fetch_pc[log2(GB)-1:2]`.
- Branch taken (`take_br`):
  - `take_br = id2_is_jump | (id2_is_branch & cond)`.
  - `cond` by encoding: BEQ `rs==rt`; BNE `rs!=rt`; BGEZ/BGEZAL `~rs[31]`; BGTZ `~rs[31] & |rs[30:0]`; BLEZ `rs[31] | ~|rs`; BLTZ/BLTZAL `rs[31]`.
  - Any other `id2_branch_sel` encoding gives `cond = 0`.
- `flush_req = exc_valid | take_br`.
- State machine, one-hot: RUN, PEND_BR, PEND_EXC. Pending target register `pend_tgt` is 32 bits.
  - RUN:
    - On `exc_valid`: if `fire`, PC <= `exc_pc`; else `pend_tgt <= exc_pc` and go to PEND_EXC.
    - Else on `take_br`: if `fire`, PC <= `id2_jmp_target`; else latch the target and go to PEND_BR.
    - Else, if `fire`, PC <= `seq`.
  - PEND_BR:
    - On `exc_valid`: `pend_tgt <= exc_pc`, go to PEND_EXC (the branch is dropped). If `fire` in the same cycle, PC <= `exc_pc` and go to RUN.
    - `take_br` is ignored in this state; ID2 is already flushed.
    - Else on `fire`: PC <= `pend_tgt`, go to RUN.
  - PEND_EXC:
    - A new `exc_valid` overwrites `pend_tgt`; `take_br` is ignored.
    - On `fire`: PC <= newest exception target, go to RUN.
- `fetch_pc` and `fetch_valid` never change while `fetch_valid & ~fetch_ready`. The held (wrong-path) request still completes, and downstream discards it because of `flush_req`.
- `redirect_pending` = state != RUN.

## Timing
- Reset values: PC = `RESET_PC`, state = RUN, `pend_tgt` = 0, `fetch_valid` = 0, `redirect_pending` = 0.
- `fetch_valid` rises on the first clock edge after `resetn` deasserts and then stays 1.
- Same-cycle redirect (`fire` together with `take_br` or `exc_valid`): the target appears on `fetch_pc` 1 cycle later.
- Stalled redirect: the target appears 1 cycle after the first `fire` that follows the resolve cycle.
- `flush_req` has zero latency and lasts exactly the resolve cycle; it is not re-asserted when a latched redirect is applied.
- Simultaneous `exc_valid` and `take_br`: the exception wins and the branch is discarded.
- Reset asserted mid-pending: the pending redirect is discarded and fetch restarts at `RESET_PC`.

## Test plan
All scenarios use `FETCH_WIDTH=2` and `RESET_PC=BFC00000`.
- Reset release with `fetch_ready=1` -> `fetch_pc` sequence is BFC00000, BFC00008, BFC00010; `fetch_slots=2` on every group.
- With `fetch_ready=1`, BEQ with rs=rt=5 and target BFC00104 -> `flush_req=1` that cycle; next `fetch_pc=BFC00104` with `fetch_slots=1`, then BFC00108.
- With `fetch_ready=0` for 3 cycles, BNE taken (rs=1, rt=2) to 80000010 -> `fetch_pc` held, `redirect_pending=1`; when `fetch_ready=1`, `fetch_pc=80000010` on the following cycle and `redirect_pending` returns to 0.
- Pending branch to 80000010, then `exc_valid` with `exc_pc=BFC00380` before any `fire` -> after the next `fire`, `fetch_pc=BFC00380`; 80000010 is never issued.
- Branch conditions:
  - BGTZ with rs=80000000 -> not taken, `flush_req=0`.
  - BLEZ with rs=0 -> taken.
  - Unknown sel 4'hF with rs=rt -> not taken.
- Wrap and reset:
  - PC at FFFFFFF8 with `fire` -> next `fetch_pc=00000000`.
  - Assert `resetn=0` during PEND_BR -> PC=BFC00000, `redirect_pending=0`, `fetch_valid=0` immediately (asynchronous).
